// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES encrypt/decrypt core.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef logic [59:0][31:0] wkeys_t;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   function automatic int nr_of(input int ks);
      return ks / 32 + 6;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the field inverse; zero maps to zero
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] p;
      sq = a;
      p  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         p  = gmul(p, sq);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
               ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] b;
      b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
        ^ {a[1:0], a[7:2]} ^ 8'h05;
      return ginv(b);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]),
              sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Key is left-aligned in 256 bits; nk = key words (4/6/8)
   function automatic wkeys_t key_expand(input logic [255:0] key,
                                         input int nk);
      wkeys_t w;
      logic [31:0] t;
      logic [7:0] rc;
      w  = '0;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) begin
         if (i < nk) begin
            w[i] = key[255-32*i -: 32];
         end else if (i < 4 * (nk + 7)) begin
            t = w[i-1];
            if (i % nk == 0) begin
               t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
               t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES round: forward or inverse, last round skips (Inv)MixColumns.
module aes_round_dp
   import aes_pkg::*;
(
   input  logic [127:0] blk,
   input  logic [127:0] rkey,
   input  logic         mode,
   input  logic         last,
   output logic [127:0] res
);

   // Byte n of the state sits at [127-8n -: 8], column-major
   function automatic logic [127:0] sub_bytes(input logic [127:0] s,
                                              input logic inv);
      logic [127:0] o;
      for (int b = 0; b < 16; b++)
         o[8*b +: 8] = inv ? inv_sbox(s[8*b +: 8]) : sbox(s[8*b +: 8]);
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s,
                                               input logic inv);
      logic [127:0] o;
      int src;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? 4 * ((c + 4 - r) % 4) + r : 4 * ((c + r) % 4) + r;
            o[127-8*(4*c+r) -: 8] = s[127-8*src -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] a,
                                           input logic inv);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      if (inv)
         return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                 gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                 gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                 gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s,
                                                input logic inv);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         o[127-32*c -: 32] = mix_col(s[127-32*c -: 32], inv);
      return o;
   endfunction

   logic [127:0] enc_s;
   logic [127:0] dec_s;

   always_comb begin
      enc_s = shift_rows(sub_bytes(blk, 1'b0), 1'b0);
      if (!last) enc_s = mix_columns(enc_s, 1'b0);
      enc_s = enc_s ^ rkey;
      dec_s = sub_bytes(shift_rows(blk, 1'b1), 1'b1) ^ rkey;
      if (!last) dec_s = mix_columns(dec_s, 1'b1);
      res = (mode == MODE_DEC) ? dec_s : enc_s;
   end

endmodule

// File: rtl/aes_core_ed.sv
// Iterative AES-128/192/256 encrypt/decrypt core with valid/ready on both sides.
// Define AES_PERF_CNT_EN to add the saturating oBlkCnt output-handshake counter.
module aes_core_ed
   import aes_pkg::*;
#(
   parameter int KEY_SIZE = 128,
   parameter int TAG_W    = 4
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iValid,
   output logic                oReady,
   input  logic                iMode,
   input  logic [127:0]        iData,
   input  logic [KEY_SIZE-1:0] iKey,
   input  logic [TAG_W-1:0]    iTag,
   output logic                oValid,
   input  logic                iReady,
   output logic [127:0]        oData,
   output logic [TAG_W-1:0]    oTag,
   output logic                oBusy
`ifdef AES_PERF_CNT_EN
   ,
   output logic [31:0]         oBlkCnt
`endif
);

   if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key
      $error("aes_core_ed: KEY_SIZE must be 128, 192 or 256");
   end

   localparam int NR = nr_of(KEY_SIZE);
   localparam int NK = KEY_SIZE / 32;
   localparam logic [3:0] NR_R = 4'(NR);

   state_t              state;
   state_t              state_n;
   logic [3:0]          rnd;
   logic [KEY_SIZE-1:0] key_q;
   logic                mode_q;
   logic [TAG_W-1:0]    tag_q;
   logic [127:0]        blk_q;
   logic [127:0]        blk_n;
   logic [127:0]        first_key;
   logic [127:0]        rkey;
   wkeys_t              w_in;
   wkeys_t              w_q;
   logic [3:0]          fidx;
   logic [3:0]          kidx;
   logic                accept;
   logic                last;

   assign oReady = (state == IDLE) || (state == DONE && iReady);
   assign oBusy  = (state == RUN);
   assign accept = iValid && oReady;
   assign last   = (rnd == NR_R);

   // The live key only feeds the whitening key of the accept cycle
   assign w_in = key_expand(256'(iKey) << (256 - KEY_SIZE), NK);
   assign w_q  = key_expand(256'(key_q) << (256 - KEY_SIZE), NK);

   assign fidx = (iMode == MODE_DEC) ? NR_R : 4'd0;
   assign kidx = (mode_q == MODE_DEC) ? NR_R - rnd : rnd;

   assign first_key = {w_in[{fidx, 2'b00}], w_in[{fidx, 2'b01}],
                       w_in[{fidx, 2'b10}], w_in[{fidx, 2'b11}]};
   assign rkey      = {w_q[{kidx, 2'b00}], w_q[{kidx, 2'b01}],
                       w_q[{kidx, 2'b10}], w_q[{kidx, 2'b11}]};

   aes_round_dp u_round (
      .blk  (blk_q),
      .rkey (rkey),
      .mode (mode_q),
      .last (last),
      .res  (blk_n)
   );

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (iValid) state_n = RUN;
         RUN:     if (last) state_n = DONE;
         DONE:    if (iReady) state_n = iValid ? RUN : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state  <= IDLE;
         rnd    <= '0;
         key_q  <= '0;
         mode_q <= MODE_ENC;
         tag_q  <= '0;
         blk_q  <= '0;
         oData  <= '0;
         oTag   <= '0;
         oValid <= 1'b0;
      end else begin
         state  <= state_n;
         oValid <= (state_n == DONE);
         if (accept) begin
            key_q  <= iKey;
            mode_q <= iMode;
            tag_q  <= iTag;
            blk_q  <= iData ^ first_key;
            rnd    <= 4'd1;
         end else if (state == RUN) begin
            blk_q <= blk_n;
            rnd   <= rnd + 4'd1;
            if (last) begin
               oData <= blk_n;
               oTag  <= tag_q;
            end
         end
      end
   end

`ifdef AES_PERF_CNT_EN
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN)
         oBlkCnt <= '0;
      else if (oValid && iReady && oBlkCnt != 32'hFFFF_FFFF)
         oBlkCnt <= oBlkCnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_aes_core_ed.sv
// Scoreboard bench for aes_core_ed: one DUT per key size, FIPS-197 vectors.
// Build with AES_PERF_CNT_EN to also check the block counter.
module tb_aes_core_ed;

   localparam logic ENC = 1'b0;
   localparam logic DEC = 1'b1;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] KEY    =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   typedef struct {
      int           idx;
      logic [127:0] data;
      logic [3:0]   tag;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ir;
   logic         mode;
   logic [127:0] din;
   logic [3:0]   tag;
   logic [255:0] key;
   logic         iv    [3];
   logic         ordy  [3];
   logic         ov    [3];
   logic         obusy [3];
   logic [127:0] od    [3];
   logic [3:0]   otg   [3];
   logic [31:0]  blk_cnt [3];
   logic         pv    [3];
   int           hs    [3];
   int           hs_base [3];
   int           cyc = 0;
   int           n_chk = 0;
   int           n_err = 0;
   exp_t         sbq [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int KS = 128 + 64 * g;
      aes_core_ed #(.KEY_SIZE(KS), .TAG_W(4)) u_dut (
         .iClk   (clk),
         .iRstN  (rst_n),
         .iValid (iv[g]),
         .oReady (ordy[g]),
         .iMode  (mode),
         .iData  (din),
         .iKey   (key[255 -: KS]),
         .iTag   (tag),
         .oValid (ov[g]),
         .iReady (ir),
         .oData  (od[g]),
         .oTag   (otg[g]),
         .oBusy  (obusy[g])
`ifdef AES_PERF_CNT_EN
         ,
         .oBlkCnt (blk_cnt[g])
`endif
      );
`ifndef AES_PERF_CNT_EN
      assign blk_cnt[g] = '0;
`endif
   end

   task automatic check(input string name, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         pv[i] = 1'b0;
         hs[i] = 0;
      end
   end

   // Monitor: latency on each rising oValid, data/tag on each handshake
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (ov[i] && !pv[i]) begin
            if (sbq.size() == 0) check("spurious_valid", ov[i], 0);
            else check("latency", cyc - sbq[0].acc, 10 + 2 * i);
         end
         if (ov[i] && ir) begin
            if (sbq.size() == 0) begin
               check("unexpected_out", ov[i], 0);
            end else begin
               e = sbq.pop_front();
               check("out_dut", i, e.idx);
               check("out_data", od[i], e.data);
               check("out_tag", otg[i], e.tag);
               hs[i]++;
            end
         end
         pv[i] = ov[i];
      end
   end

   task automatic send(input int i, input logic m, input logic [127:0] d,
                       input logic [3:0] t, input logic [127:0] e,
                       output int acc);
      bit ok;
      ok    = 1'b0;
      mode  = m;
      din   = d;
      tag   = t;
      key   = KEY;
      iv[i] = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (ordy[i]) begin
            ok = 1'b1;
            break;
         end
      end
      check("accept", ok, 1);
      acc = cyc + 1;
      if (ok) sbq.push_back('{i, e, t, acc});
      @(posedge clk);
      #1;
      iv[i] = 1'b0;
      mode  = ~m;
      din   = {$urandom(), $urandom(), $urandom(), $urandom()};
      tag   = ~t;
      key   = {8{$urandom()}};
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", sbq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int a1, a2, a3;
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, a3;
      rst_n = 1'b0;
      ir    = 1'b1;
      mode  = ENC;
      din   = '0;
      tag   = '0;
      key   = KEY;
      for (int i = 0; i < 3; i++) iv[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("rst_valid", ov[i], 0);
         check("rst_busy", obusy[i], 0);
         check("rst_ready", ordy[i], 1);
         check("rst_data", od[i], 0);
         check("rst_tag", otg[i], 0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(0, ENC, PT, 4'h2, CT128, a1);
      check("run_busy", obusy[0], 1);
      check("run_ready", ordy[0], 0);
      drain();
      send(0, DEC, CT128, 4'hA, PT, a1);
      drain();
      send(1, ENC, PT, 4'h6, CT192, a1);
      drain();
      send(1, DEC, CT192, 4'h9, PT, a1);
      drain();
      send(2, ENC, PT, 4'h7, CT256, a1);
      drain();
      send(2, DEC, CT256, 4'h8, PT, a1);
      drain();

      // Backpressure with a new block pending, then overlap
      ir = 1'b0;
      send(0, ENC, PT, 4'h3, CT128, a1);
      for (int n = 0; n < 40 && !ov[0]; n++) @(negedge clk);
      check("bp_valid", ov[0], 1);
      mode  = DEC;
      din   = CT128;
      tag   = 4'h5;
      key   = KEY;
      iv[0] = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("bp_data", od[0], CT128);
         check("bp_tag", otg[0], 4'h3);
         check("bp_ready", ordy[0], 0);
      end
      @(posedge clk);
      #1;
      ir = 1'b1;
      send(0, DEC, CT128, 4'h5, PT, a1);
      check("ovl_valid_drop", ov[0], 0);
      check("ovl_busy", obusy[0], 1);
      drain();

      send(0, ENC, PT, 4'h1, CT128, a1);
      send(0, DEC, CT128, 4'h4, PT, a2);
      send(0, ENC, PT, 4'hE, CT128, a3);
      check("thru_1", a2 - a1, 11);
      check("thru_2", a3 - a2, 11);
      drain();

      // Reset mid-block at round 5
      send(0, ENC, PT, 4'hB, CT128, a1);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", ov[0], 0);
      check("abort_busy", obusy[0], 0);
      check("abort_ready", ordy[0], 1);
`ifdef AES_PERF_CNT_EN
      check("abort_cnt", blk_cnt[0], 0);
`endif
      sbq.delete();
      for (int i = 0; i < 3; i++) hs_base[i] = hs[i];
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("abort_no_valid", ov[0], 0);
      @(posedge clk);
      #1;
      send(0, ENC, PT, 4'hC, CT128, a1);
      drain();
`ifdef AES_PERF_CNT_EN
      for (int i = 0; i < 3; i++)
         check("blk_cnt", blk_cnt[i], hs[i] - hs_base[i]);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/aes_core_ed.md
Name: aes_core_ed

Overview:
- Iterative AES core performing both encryption and decryption, one round per clock, for 128/192/256-bit keys.
- Successor to the encrypt-only core. Adds:
  - valid/ready handshakes on input and output
  - a per-block mode select
  - a key latched per block
  - a pass-through tag
  - back-to-back block acceptance
- Sits between the host-side buffering and the result FIFO. Uses the existing KeyExpansion on a latched key.

Parameters:
- KEY_SIZE, 128, key width; only 128, 192 or 256 are legal, any other value is an elaboration error. Nr = 10/12/14 respectively.
- TAG_W, 4, width of the user tag carried from input to output unchanged.

Ports:
- iClk  in  1  clock
- iRstN  in  1  asynchronous active-low reset
- iValid  in  1  input block valid
- oReady  out  1  core can accept a block this cycle
- iMode  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- iData  in  128  plaintext (encrypt) or ciphertext (decrypt)
- iKey  in  KEY_SIZE  cipher key; sampled on accept
- iTag  in  TAG_W  user tag; sampled on accept
- oValid  out  1  result valid
- iReady  in  1  downstream accepts result
- oData  out  128  result block
- oTag  out  TAG_W  tag of the result block
- oBusy  out  1  high while rounds are in progress

Behaviour:
- Reset (iRstN low, asynchronous):
  - state = IDLE
  - oValid = 0, oBusy = 0
  - oData = 0, oTag = 0
  - round counter, key register and mode register = 0
  - oReady is combinational and therefore 1 after reset.
- Round keys: w[0..Nr] come from KeyExpansion fed by the latched key register, never by iKey directly.
- States:
  - IDLE: waiting for a block.
  - RUN: round counter r counts 1..Nr.
  - DONE: result held until taken.
- oReady is combinational: oReady = (state == IDLE) || (state == DONE && iReady).
- Accept when iValid && oReady.
  - Latch key, mode and tag.
  - Load state = iData ^ iKey-derived first key: w[0] for encrypt, w[Nr] for decrypt. This key is computed from iKey combinationally only in the accept cycle.
  - Set r = 1 and go to RUN.
- Encrypt, RUN round r:
  - r < Nr: SubBytes → ShiftRows → MixColumns → XOR w[r].
  - r = Nr: MixColumns is bypassed.
- Decrypt, RUN round r, using key index k = Nr - r:
  - InvShiftRows → InvSubBytes → XOR w[k], then InvMixColumns if r < Nr.
- At r == Nr:
  - Register the result into oData and the latched tag into oTag.
  - Set oValid = 1 and go to DONE.
- Latency: oValid rises exactly Nr clock edges after the accepting edge. This is 10/12/14 cycles, mode-independent.
- Throughput: one block per Nr+1 cycles with continuous iReady.
- DONE:
  - oData, oTag and oValid are held stable until iReady.
  - iReady && !iValid: oValid drops next cycle, go to IDLE.
  - iReady && iValid (simultaneous): the result is retired and the new block accepted on the same edge; oValid drops and RUN starts.
- Backpressure: iReady low holds DONE indefinitely with no data change. iValid is ignored while oReady = 0.
- oBusy = (state == RUN).
- Changes to iKey, iMode or iTag after accept do not affect the block in flight.
- Reset asserted mid-operation aborts the block; no oValid is produced for it.

Optional Feature:
- Macro AES_PERF_CNT_EN.
- Defined:
  - Adds output oBlkCnt [31:0], reset to 0.
  - Increments on each output handshake (oValid && iReady).
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package aes_pkg holds:
  - function nr_of(KEY_SIZE)
  - FSM state encoding: IDLE/RUN/DONE
  - mode constants MODE_ENC = 0, MODE_DEC = 1
- Sub-module aes_round_dp: combinational forward and inverse round.
  - Inputs: state, round key, mode, last-round flag.
  - Instantiates the existing SubBytes, ShiftRows and MixColumns, plus new InvSubBytes, InvShiftRows and InvMixColumns.
- The top level holds the FSM, registers and KeyExpansion.

Test Plan:
- KEY_SIZE=128, encrypt, PT 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → oData 69c4e0d86a7b0430d8cdb78070b4c55a, oValid exactly 10 cycles after accept.
- KEY_SIZE=128, decrypt, data 69c4e0d86a7b0430d8cdb78070b4c55a with the same key → 00112233445566778899aabbccddeeff; oTag equals the iTag given (e.g. 4'hA).
- KEY_SIZE=192, key 000102…1617, encrypt the same PT → dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles.
- KEY_SIZE=256, key 000102…1e1f, encrypt the same PT → 8ea2b7ca516745bfeafc49904b496089 after 14 cycles; then decrypt it back → original PT.
- Backpressure and overlap:
  - Hold iReady = 0 for 20 cycles in DONE → oData/oTag stable, oReady = 0.
  - Then assert iReady together with iValid → the next block is accepted on the same edge.
  - With iReady held high, measured throughput is 11 cycles per block (KEY_SIZE=128).
- Reset mid-operation: drop iRstN at r = 5 → oValid = 0 and oBusy = 0 immediately, oReady = 1; with AES_PERF_CNT_EN, oBlkCnt = 0.
